// File: rtl/adc_spi_responder_if.sv
// Serial link between adc_driver (master) and the ADC responder (slave).
// Signal names are written from the responder's point of view.
interface adc_spi_responder_if;
    logic cs_i;        // chip select, active-low
    logic din_i;       // serial config, driver -> ADC
    logic dout_o;      // serial sample, ADC -> driver
    logic dout_oe_o;   // dout_o is being actively driven

    modport master (output cs_i, din_i, input dout_o, dout_oe_o);
    modport slave  (input cs_i, din_i, output dout_o, dout_oe_o);
endinterface

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: synthesizable target end of the 2-channel SPI ADC protocol.
// Decodes start + {SGL, ODD, MSBF}, latches a sample, then returns a null bit and
// DATA_W bits MSB-first, optionally followed by an LSB-first tail.
// Optional feature macro: ADC_RAMP_GEN_EN (internal ramp replaces the channel inputs).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start bit (cs low, din high)
// CFG    | shifting in SGL, ODD, MSBF
// NULL   | null bit on dout, sample latched
// DATA   | sending sample MSB -> LSB
// TAIL   | sending bits 1..DATA_W-1 LSB-first (MSBF = 0 only)
// HOLD   | conversion finished, dout held 0 until cs goes high
module adc_spi_responder #(
    parameter int DATA_W    = 10,
    parameter int RAMP_STEP = 1
) (
    input  logic                  s_clk_i,
    input  logic                  rst_i,
    adc_spi_responder_if.slave    spi_if,
    input  logic [DATA_W-1:0]     ch0_data_i,
    input  logic [DATA_W-1:0]     ch1_data_i,
    output logic [DATA_W-1:0]     sample_o,
    output logic [2:0]            cfg_o,
    output logic                  busy_o,
    output logic                  conv_done_o
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_NULL, S_DATA, S_TAIL, S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          cfg_sh_q, cfg_sh_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [2:0]          cfg_q, cfg_d;
    logic                dout_q, dout_d;
    logic                oe_q, oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   ch0_w, ch1_w, sel_w;
    logic [DATA_W:0]     diff_w;

`ifdef ADC_RAMP_GEN_EN
    logic [DATA_W-1:0]   ramp_q;
    wire                 unused_ch = ^{ch0_data_i, ch1_data_i};

    assign ch0_w = ramp_q;
    assign ch1_w = ~ramp_q;

    // Ramp advances once per completed conversion; aborts leave it alone.
    always_ff @(posedge s_clk_i or posedge rst_i) begin
        if (rst_i)       ramp_q <= '0;
        else if (done_d) ramp_q <= ramp_q + DATA_W'(RAMP_STEP);
    end
`else
    localparam int unused_ramp_step = RAMP_STEP;

    assign ch0_w = ch0_data_i;
    assign ch1_w = ch1_data_i;
`endif

    // Channel select from the SGL/ODD bits already shifted in; pseudo-diff saturates at 0.
    always_comb begin
        diff_w = cfg_sh_q[0] ? ({1'b0, ch1_w} - {1'b0, ch0_w})
                             : ({1'b0, ch0_w} - {1'b0, ch1_w});
        sel_w  = '0;
        if (cfg_sh_q[1])          sel_w = cfg_sh_q[0] ? ch1_w : ch0_w;
        else if (!diff_w[DATA_W]) sel_w = diff_w[DATA_W-1:0];
    end

    // State and output registers.
    always_ff @(posedge s_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cfg_sh_q <= '0;
            sample_q <= '0;
            cfg_q    <= '0;
            dout_q   <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_sh_q <= cfg_sh_d;
            sample_q <= sample_d;
            cfg_q    <= cfg_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and registered-output logic; cs high overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cfg_sh_d = cfg_sh_q;
        sample_d = sample_q;
        cfg_d    = cfg_q;
        dout_d   = 1'b0;
        oe_d     = oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                oe_d   = 1'b0;
                busy_d = 1'b0;
                if (spi_if.din_i) begin
                    state_d = S_CFG;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_CFG: begin
                cfg_sh_d = {cfg_sh_q[0], spi_if.din_i};
                if (cnt_q == CW'(2)) begin
                    sample_d = sel_w;
                    cfg_d    = {cfg_sh_q, spi_if.din_i};
                    oe_d     = 1'b1;
                    state_d  = S_NULL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_NULL: begin
                dout_d  = sample_q[DATA_W-1];
                cnt_d   = CW'(DATA_W - 1);
                state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    if (cfg_q[0]) begin
                        done_d  = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        // LSB already went out, so the tail restarts at bit 1.
                        dout_d  = sample_q[1];
                        cnt_d   = CW'(1);
                        state_d = S_TAIL;
                    end
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    dout_d = sample_q[cnt_d];
                end
            end
            S_TAIL: begin
                if (cnt_q == CW'(DATA_W - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    dout_d = sample_q[cnt_d];
                end
            end
            S_HOLD: ;
            default: state_d = S_IDLE;
        endcase

        if (spi_if.cs_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            dout_d  = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign spi_if.dout_o    = dout_q;
    assign spi_if.dout_oe_o = oe_q;
    assign sample_o         = sample_q;
    assign cfg_o            = cfg_q;
    assign busy_o           = busy_q;
    assign conv_done_o      = done_q;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: directed vector table, abort and
// reset corner cases, and randomized conversions against a behavioural model.
module tb_adc_spi_responder;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] ch0 = '0, ch1 = '0;
    logic [DW-1:0] sample;
    logic [2:0]    cfg;
    logic          busy, done;

    int checks = 0;
    int errors = 0;

    adc_spi_responder_if spi ();

    adc_spi_responder #(.DATA_W(DW), .RAMP_STEP(1)) dut (
        .s_clk_i     (clk),
        .rst_i       (rst),
        .spi_if      (spi.slave),
        .ch0_data_i  (ch0),
        .ch1_data_i  (ch1),
        .sample_o    (sample),
        .cfg_o       (cfg),
        .busy_o      (busy),
        .conv_done_o (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what the ADC should convert for given channel values and config.
    function automatic logic [DW-1:0] ref_sample(input int a, input int b, input bit sgl, input bit odd);
        int d;
        if (sgl) return odd ? DW'(b) : DW'(a);
        d = odd ? (b - a) : (a - b);
        return (d < 0) ? '0 : DW'(d);
    endfunction

    // One full conversion; abort_at >= 0 raises cs after that many serial bits.
    task automatic run_conv(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                            input bit sgl, input bit odd, input bit msbf,
                            input logic [DW-1:0] exp, input int abort_at);
        bit q[$];
        ch0 = c0; ch1 = c1;
        spi.cs_i = 1'b0; spi.din_i = 1'b1;
        tick();
        chk("busy_after_start", busy, 1);
        spi.din_i = sgl;  tick();
        spi.din_i = odd;  tick();
        spi.din_i = msbf; tick();
        spi.din_i = 1'b0;
        chk("null_bit", spi.dout_o, 0);
        chk("null_oe", spi.dout_oe_o, 1);
        chk("sample_latched", sample, exp);
        chk("cfg_latched", cfg, {sgl, odd, msbf});
        for (int i = DW - 1; i >= 0; i--) q.push_back(exp[i]);
        if (!msbf) for (int i = 1; i < DW; i++) q.push_back(exp[i]);
        foreach (q[k]) begin
            if (k == abort_at) begin
                spi.cs_i = 1'b1;
                tick();
                chk("abort_oe", spi.dout_oe_o, 0);
                chk("abort_busy", busy, 0);
                chk("abort_no_done", done, 0);
                chk("abort_dout", spi.dout_o, 0);
                chk("abort_keeps_sample", sample, exp);
                tick();
                chk("abort_no_done_later", done, 0);
                return;
            end
            tick();
            chk("data_bit", spi.dout_o, q[k]);
            chk("data_oe", spi.dout_oe_o, 1);
            chk("no_early_done", done, 0);
        end
        tick();
        chk("conv_done_pulse", done, 1);
        chk("dout_zero_end", spi.dout_o, 0);
        tick();
        chk("conv_done_single", done, 0);
        chk("hold_dout", spi.dout_o, 0);
        spi.din_i = 1'b1;   // restart attempt with cs still low must be ignored
        tick();
        chk("hold_busy", busy, 1);
        chk("hold_no_restart_dout", spi.dout_o, 0);
        chk("hold_no_done", done, 0);
        spi.cs_i = 1'b1; spi.din_i = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_oe", spi.dout_oe_o, 0);
    endtask

    typedef struct {
        logic [DW-1:0] c0;
        logic [DW-1:0] c1;
        bit            sgl, odd, msbf;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        spi.cs_i = 1'b1; spi.din_i = 1'b0;
        vecs[0] = '{10'h12C, 10'h000, 1, 0, 1, 10'h12C};
        vecs[1] = '{10'h000, 10'h124, 1, 1, 1, 10'h124};
        vecs[2] = '{10'h200, 10'h080, 0, 0, 1, 10'h180};
        vecs[3] = '{10'h200, 10'h080, 0, 1, 1, 10'h000};
        vecs[4] = '{10'h2A5, 10'h000, 1, 0, 0, 10'h2A5};

        tick(); tick();
        chk("rst_dout", spi.dout_o, 0);
        chk("rst_oe", spi.dout_oe_o, 0);
        chk("rst_sample", sample, 0);
        chk("rst_cfg", cfg, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Leading zeros on din with cs low do not start a conversion.
        spi.cs_i = 1'b0; spi.din_i = 1'b0;
        tick(); tick();
        chk("leading_zero_idle", busy, 0);
        spi.cs_i = 1'b1;
        tick();

`ifdef ADC_RAMP_GEN_EN
        run_conv('0, '0, 1, 0, 1, 10'h000, -1);
        run_conv('0, '0, 1, 0, 1, 10'h001, -1);
        run_conv('0, '0, 1, 0, 1, 10'h002, -1);
        run_conv('0, '0, 1, 1, 1, 10'h3FC, -1);
`else
        foreach (vecs[i])
            run_conv(vecs[i].c0, vecs[i].c1, vecs[i].sgl, vecs[i].odd, vecs[i].msbf, vecs[i].exp, -1);

        // Abort after the 4th data bit (null bit is not counted), then recover.
        run_conv(10'h2A5, 10'h000, 1, 0, 1, 10'h2A5, 4);
        run_conv(10'h155, 10'h000, 1, 0, 1, 10'h155, -1);

        // Reset in the middle of the data phase.
        run_conv(10'h3FF, 10'h000, 1, 0, 0, 10'h3FF, 7);
        ch0 = 10'h1F0; spi.cs_i = 1'b0; spi.din_i = 1'b1; tick();
        spi.din_i = 1'b1; tick(); spi.din_i = 1'b0; tick(); spi.din_i = 1'b1; tick();
        tick(); tick();
        #2 rst = 1'b1; #1;
        chk("midrst_oe", spi.dout_oe_o, 0);
        chk("midrst_sample", sample, 0);
        chk("midrst_cfg", cfg, 0);
        chk("midrst_busy", busy, 0);
        tick();
        chk("midrst_no_done", done, 0);
        spi.cs_i = 1'b1; spi.din_i = 1'b0;
        rst = 1'b0;
        tick();

        // Randomized conversions checked against the reference model.
        for (int n = 0; n < 24; n++) begin
            logic [DW-1:0] a, b;
            bit s, o, m;
            a = DW'($urandom_range(0, 1023));
            b = DW'($urandom_range(0, 1023));
            s = 1'($urandom_range(0, 1));
            o = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            run_conv(a, b, s, o, m, ref_sample(int'(a), int'(b), s, o),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
